// File: rtl/int_to_float_conv.sv
// Three-stage signed fixed-point to packed float converter with valid/ready flow.
// Define INT2F_RNE_EN for round-to-nearest-even; the default build truncates.
module int_to_float_conv #(
    parameter int N_INT     = 32,
    parameter int FRAC_BITS = 0,
    parameter int n_exp     = 8,
    parameter int n_mant    = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_INT-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [n_exp+n_mant+1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef struct packed {
        logic              sign;
        logic [n_exp-1:0]  exp;
        logic [n_mant:0]   mant;
    } float_t;

    localparam int PW   = $clog2(N_INT);
    localparam int EW   = n_exp + 2;
    localparam int XW   = N_INT + n_mant + 1;
    localparam int BIAS = 2**(n_exp-1) - 1;

    logic             v1_q, v2_q, ov_q;
    logic             s1_q, s2_q, zero_q;
    logic [N_INT-1:0] mag_q, norm_q;
    logic [PW-1:0]    p_q;
    float_t           out_q;

    logic             adv1, adv2, adv3;
    logic [N_INT-1:0] mag_d, norm_d;
    logic [PW-1:0]    p_d;
    float_t           out_d;

    logic [XW-1:0]    ext;
    logic [n_mant:0]  frac, mant;
    logic             carry;
    logic signed [EW-1:0] e;

    assign adv3      = !ov_q || out_ready;
    assign adv2      = !v2_q || adv3;
    assign adv1      = !v1_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = ov_q;
    assign out_data  = out_q;

    // Unsigned magnitude: the most negative input maps to 2^(N_INT-1).
    always_comb begin
        mag_d = in_data;
        if (in_data[N_INT-1])
            mag_d = ~in_data + N_INT'(1);
    end

    always_comb begin
        p_d = '0;
        for (int i = 0; i < N_INT; i++)
            if (mag_q[i]) p_d = PW'(i);
        norm_d = mag_q << (PW'(N_INT - 1) - p_d);
    end

    // Drop the leading one; pad below so guard/sticky exist for any width.
    always_comb begin
        ext  = {norm_q[N_INT-2:0], {(n_mant + 2){1'b0}}};
        frac = ext[XW-1 -: n_mant+1];
`ifdef INT2F_RNE_EN
        begin
            logic guard, sticky, rnd_up;
            guard  = ext[N_INT-1];
            sticky = |ext[N_INT-2:0];
            rnd_up = guard && (sticky || frac[0]);
            {carry, mant} = {1'b0, frac} + (n_mant + 2)'(rnd_up);
        end
`else
        carry = 1'b0;
        mant  = frac;
`endif
        e = EW'(BIAS + int'(p_q) - FRAC_BITS + int'(carry));
        out_d = '0;
        if (zero_q) begin
            out_d = '0;
        end else if (int'(e) < 1) begin
            out_d.sign = s2_q;
        end else if (int'(e) >= 2**n_exp - 1) begin
            out_d.sign = s2_q;
            out_d.exp  = n_exp'(2**n_exp - 2);
            out_d.mant = '1;
        end else begin
            out_d.sign = s2_q;
            out_d.exp  = e[n_exp-1:0];
            out_d.mant = mant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            ov_q  <= 1'b0;
            out_q <= '0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) ov_q <= v2_q;
            if (adv3 && v2_q) out_q <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_q  <= in_data[N_INT-1];
            mag_q <= mag_d;
        end
        if (adv2 && v1_q) begin
            s2_q   <= s1_q;
            norm_q <= norm_d;
            p_q    <= p_d;
            zero_q <= (mag_q == '0);
        end
    end

endmodule

// File: tb/tb_int_to_float_conv.sv
// Randomised scoreboard bench for int_to_float_conv, plus directed values.
// Three extra instances cover FRAC_BITS=16, FRAC_BITS=140 and a 4-bit exponent.
module tb_int_to_float_conv;

    localparam int FB[4] = '{0, 16, 140, 10};
    localparam int NE[4] = '{8, 8, 8, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic [31:0] od0, od1, od2;
    logic [27:0] od3;
    logic        ov0, ov1, ov2, ov3;
    logic        ir0, ir1, ir2, ir3;

    logic [31:0] od [4];
    logic        ov [4];
    logic        ir [4];
    logic        rdy[4];

    logic [31:0] sbq[4][$];
    logic        stall_q = 1'b0;
    logic [31:0] hold_d  = '0;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int_to_float_conv u_main (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready)
    );
    int_to_float_conv #(.FRAC_BITS(16)) u_fb16 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(1'b1)
    );
    int_to_float_conv #(.FRAC_BITS(140)) u_fb140 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(1'b1)
    );
    int_to_float_conv #(.FRAC_BITS(10), .n_exp(4)) u_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir3), .out_data(od3), .out_valid(ov3), .out_ready(1'b1)
    );

    always_comb begin
        od[0] = od0; od[1] = od1; od[2] = od2; od[3] = {4'b0, od3};
        ov[0] = ov0; ov[1] = ov1; ov[2] = ov2; ov[3] = ov3;
        ir[0] = ir0; ir[1] = ir1; ir[2] = ir2; ir[3] = ir3;
        rdy[0] = out_ready; rdy[1] = 1'b1; rdy[2] = 1'b1; rdy[3] = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value-level model: magnitude, binade, scaled quotient and remainder.
    function automatic logic [31:0] ref_conv(input logic [31:0] x,
                                             input int fb, input int ne);
        longint m, q, r, one, res;
        int     p, e;
        logic   s;
        s = x[31];
        m = longint'($signed(x));
        if (s) m = -m;
        if (m == 0) return 32'h0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        one = longint'(1) << p;
        q = (m << 23) / one;
        r = (m << 23) % one;
`ifdef INT2F_RNE_EN
        if (2 * r > one || (2 * r == one && (q % 2) == 1)) q++;
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            p++;
        end
`else
        if (r < 0) q = 0;
`endif
        e   = (1 << (ne - 1)) - 1 + p - fb;
        res = longint'(s) << (ne + 23);
        if (e >= (1 << ne) - 1)
            res = res | (longint'((1 << ne) - 2) << 23) | 64'h7FFFFF;
        else if (e >= 1)
            res = res | (longint'(e) << 23) | (q - (longint'(1) << 23));
        return res[31:0];
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                sbq[k].delete();
            end else begin
                if (ov[k] && rdy[k]) begin
                    if (sbq[k].size() == 0)
                        chk($sformatf("stale%0d", k), 32'd1, 32'd0);
                    else
                        chk($sformatf("sb%0d", k), od[k], sbq[k].pop_front());
                end
                if (in_valid && ir[k])
                    sbq[k].push_back(ref_conv(in_data, FB[k], NE[k]));
            end
        end
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_v", {31'b0, ov0}, 32'd1);
                chk("hold_d", od0, hold_d);
            end
            stall_q = ov0 && !out_ready;
            hold_d  = od0;
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] exp,
                        input string tag);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ov0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'd3);
        chk(tag, od0, exp);
    endtask

    task automatic push(input logic [31:0] x);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!ir0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("push_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] x;
        case ($urandom_range(0, 9))
            0: x = 32'h0;
            1: x = 32'h8000_0000;
            default: x = $urandom >> $urandom_range(0, 31);
        endcase
        if ($urandom_range(0, 1) == 1) x = -x;
        return x;
    endfunction

    task automatic drain();
        int w;
        w = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()
                + sbq[3].size()) != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sbq[0].size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ov", {31'b0, ov0}, 32'd0);
        chk("rst_od", od0, 32'd0);
        @(negedge clk);
        chk("rst_ir", {31'b0, ir0}, 32'd1);

        send(32'd1, 32'h3F80_0000, "one");
        chk("fb140_one", od2, 32'h0);
        send(-32'sd3, 32'hC040_0000, "neg3");
        chk("small_flush", od[3], 32'h0800_0000);
        send(32'd0, 32'h0, "zero");
        send(32'h8000_0000, 32'hCF00_0000, "minneg");
        chk("small_sat", od[3], 32'h0F7F_FFFF);
        send(32'd16777217, 32'h4B80_0000, "tie_even");
`ifdef INT2F_RNE_EN
        send(32'd16777219, 32'h4B80_0002, "round_up");
        send(32'd33554431, 32'h4C00_0000, "carry");
`else
        send(32'd16777219, 32'h4B80_0001, "trunc");
        send(32'd33554431, 32'h4BFF_FFFF, "trunc_max");
`endif
        send(32'h0001_8000, 32'h47C0_0000, "frac_src");
        chk("fb16_1p5", od1, 32'h3FC0_0000);

        // Fill all three stages with the output stalled.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rnd_val());
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("full_ir", {31'b0, ir0}, 32'd0);

        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    push(rnd_val());
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        // Reset with the pipeline full must discard everything in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'd100 + i);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ov", {31'b0, ov0}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale", {31'b0, ov0}, 32'd0);
        end
        send(32'd7, 32'h40E0_0000, "after_rst");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_to_float_conv.md
Name: int_to_float_conv

Overview:
- Pipelined converter from signed fixed-point samples to the packed float format consumed by the FPU adder/multiplier stages.
- Sits directly upstream of the FPU: filter-side integer/fixed-point data enters here, normalised floats leave toward FPU operand inputs.
- Valid/ready streaming on both sides.
- Fixed latency of 3 cycles when not stalled.

Parameters:
- N_INT, 32: width of signed two's-complement input.
- FRAC_BITS, 0: input binary point position; value = in_data / 2^FRAC_BITS.
- n_exp, 8: float exponent field width.
- n_mant, 22: float mantissa field is n_mant+1 bits (fraction only, hidden leading one).
- float_t, struct packed {logic sign; logic[n_exp-1:0] exp; logic[n_mant:0] mant;}: output type.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_data  input  N_INT  signed fixed-point sample
- in_valid  input  1  in_data valid
- in_ready  output  1  stage 1 can accept
- out_data  output  $bits(float_t)  converted float
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, all internal stage valids=0. in_ready=1 one cycle after reset deasserts. Reset mid-stream discards all in-flight samples and emits no partial output.
- Handshake: transfer on valid&&ready. Each stage i advances when !valid_i || ready_i, where ready_3=out_ready. in_ready = !valid_1 || advance_1.
- Zero-bubble throughput: 1 sample/cycle when out_ready=1.
- out_data and out_valid are held stable while out_valid && !out_ready. in_data is ignored when in_valid=0.
- Stage 1 (sign/abs):
  - sign = in_data[N_INT-1].
  - mag = |in_data| as N_INT-bit unsigned.
  - Most negative input -2^(N_INT-1) gives mag = 2^(N_INT-1) with no overflow.
- Stage 2 (normalise):
  - Priority encoder finds msb index p of mag.
  - mag is left-shifted so bit p lands at bit N_INT-1.
  - zero flag = (mag==0).
- Stage 3 (round/pack):
  - Fraction = the n_mant+1 bits below the leading one.
  - Remaining lower bits form guard/round/sticky; rounding per Optional Feature.
  - Mantissa carry-out on rounding sets mant=0 and exp+1.
  - Exponent computed signed, width n_exp+2: e = (2^(n_exp-1)-1) + p - FRAC_BITS (+1 on rounding carry).
- Boundary conditions:
  - Zero input -> out_data all zeros (sign 0).
  - e < 1 -> flush to signed zero: sign kept, exp=0, mant=0. No denormals.
  - e >= 2^n_exp - 1 -> saturate: exp = 2^n_exp - 2, mant all ones, sign kept.
  - If N_INT-1 <= n_mant+1, no rounding occurs and the fraction is zero-padded.

Optional Feature:
- Macro: INT2F_RNE_EN.
- Defined: round-to-nearest-even using guard/sticky bits, with exponent increment on mantissa overflow.
- Undefined: truncation toward zero. Rounding logic is not instantiated and no carry path exists.
- Latency is 3 cycles in both builds.

Test Plan:
- Defaults (N_INT=32, FRAC_BITS=0, n_exp=8, n_mant=22), in_data=1 -> out_data=0x3F800000 after 3 cycles. in_data=-3 -> 0xC0400000. in_data=0 -> 0x00000000.
- in_data=-2147483648 -> 0xCF000000, with no overflow artefacts.
- Rounding:
  - in_data=16777217 -> 0x4B800000 with INT2F_RNE_EN (tie to even) and 0x4B800000 without it.
  - in_data=16777219 -> 0x4B800002 with RNE, 0x4B800001 truncated.
  - in_data=33554431 -> 0x4C000000 with RNE (carry into exponent).
- FRAC_BITS=16, in_data=0x00018000 (1.5) -> 0x3FC00000. FRAC_BITS=140, in_data=1 -> flush to 0x00000000.
- Backpressure: stream 8 values with out_ready toggled randomly and held low 5 cycles. Required: no loss, duplication or reorder; out_data stable while stalled; in_ready=0 once all 3 stages are full.
- Reset: assert rst for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, and no stale sample appears afterwards.
